// File: rtl/adc_spi_sampler_if.sv
// Bundle of the sampler's request/result handshake and the LTC2308 SPI pins.
// master = the sampler (drives SPI and results); slave = the ADC/consumer side.
interface adc_spi_sampler_if;
  logic        sample_tick;
  logic        ADC_DOUT;
  logic        ADC_SCLK;
  logic        ADC_CS_N;
  logic        ADC_DIN;
  logic [11:0] meas_value;
  logic        meas_valid;
  logic        busy;

  modport master (
    input  sample_tick, ADC_DOUT,
    output ADC_SCLK, ADC_CS_N, ADC_DIN, meas_value, meas_valid, busy
  );

  modport slave (
    output sample_tick, ADC_DOUT,
    input  ADC_SCLK, ADC_CS_N, ADC_DIN, meas_value, meas_valid, busy
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: LTC2308 CONVST/SPI conversion controller, one conversion per sample_tick.
// Optional ADC_OVERSAMPLE_EN: four back-to-back conversions per tick, averaged into meas_value.
module adc_spi_sampler #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int CHANNEL     = 0,
  parameter int UNIPOLAR    = 1
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_sampler_if.master bus
);
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'd11;

  // Config word in ADC shift order: S/D, O/S, S1, S0, UNI, SLP.
  function automatic logic [5:0] cfg_word(input int ch, input int uni);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2:1], 1'(uni), 1'b0};
  endfunction

  localparam logic [5:0] CFG = cfg_word(CHANNEL, UNIPOLAR);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    XFER = 3'd2,
`ifdef ADC_OVERSAMPLE_EN
    GAP  = 3'd4,
`endif
    DONE = 3'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   conv_cnt_r, conv_cnt_nxt_s;
  logic [DW-1:0]   div_cnt_r, div_cnt_nxt_s;
  logic [3:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic            sclk_r, sclk_nxt_s;
  logic            cs_n_r, cs_n_nxt_s;
  logic [5:0]      cfg_sh_r, cfg_sh_nxt_s;
  logic [11:0]     shift_r, shift_nxt_s;
  logic [11:0]     meas_value_r, meas_value_nxt_s;
  logic            meas_valid_r, meas_valid_nxt_s;
  logic            busy_r, busy_nxt_s;
`ifdef ADC_OVERSAMPLE_EN
  logic [13:0]     acc_r, acc_nxt_s, sum_s;
  logic [1:0]      idx_r, idx_nxt_s;
  logic            gap_r, gap_nxt_s;
`endif

  // Next-state and next-output decode for the conversion sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    conv_cnt_nxt_s   = conv_cnt_r;
    div_cnt_nxt_s    = div_cnt_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    sclk_nxt_s       = 1'b0;
    cs_n_nxt_s       = 1'b0;
    cfg_sh_nxt_s     = cfg_sh_r;
    shift_nxt_s      = shift_r;
    meas_value_nxt_s = meas_value_r;
    meas_valid_nxt_s = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
    acc_nxt_s        = acc_r;
    idx_nxt_s        = idx_r;
    gap_nxt_s        = gap_r;
    sum_s            = acc_r + {2'b00, shift_r};
`endif
    case (state_r)
      IDLE: begin
        // busy_r still covers the strobe cycle right after DONE
        if (bus.sample_tick && !busy_r) begin
          state_nxt_s    = CONV;
          conv_cnt_nxt_s = {CW{1'b0}};
          cs_n_nxt_s     = 1'b1;
          cfg_sh_nxt_s   = CFG;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      CONV: begin
        if (conv_cnt_r == CONV_LAST) begin
          state_nxt_s   = XFER;
          div_cnt_nxt_s = {DW{1'b0}};
          bit_cnt_nxt_s = 4'd0;
          cs_n_nxt_s    = 1'b0;
        end else begin
          conv_cnt_nxt_s = conv_cnt_r + 1'b1;
          cs_n_nxt_s     = 1'b1;
        end
      end
      XFER: begin
        sclk_nxt_s = sclk_r;
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_nxt_s = {DW{1'b0}};
          sclk_nxt_s    = ~sclk_r;
          if (!sclk_r) begin
            shift_nxt_s = {shift_r[10:0], bus.ADC_DOUT};
          end else begin
            cfg_sh_nxt_s = {cfg_sh_r[4:0], 1'b0};
            if (bit_cnt_r == BIT_LAST) begin
              state_nxt_s = DONE;
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            end
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + 1'b1;
        end
      end
`ifdef ADC_OVERSAMPLE_EN
      DONE: begin
        if (idx_r == 2'd3) begin
          meas_value_nxt_s = sum_s[13:2];
          meas_valid_nxt_s = 1'b1;
          acc_nxt_s        = 14'd0;
          idx_nxt_s        = 2'd0;
          state_nxt_s      = IDLE;
        end else begin
          acc_nxt_s   = sum_s;
          idx_nxt_s   = idx_r + 2'd1;
          gap_nxt_s   = 1'b0;
          state_nxt_s = GAP;
        end
      end
      GAP: begin
        if (gap_r) begin
          state_nxt_s    = CONV;
          conv_cnt_nxt_s = {CW{1'b0}};
          cs_n_nxt_s     = 1'b1;
          cfg_sh_nxt_s   = CFG;
        end else begin
          gap_nxt_s = 1'b1;
        end
      end
`else
      DONE: begin
        meas_value_nxt_s = shift_r;
        meas_valid_nxt_s = 1'b1;
        state_nxt_s      = IDLE;
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE) || (state_r == DONE);
  end

  // State, counters and registered outputs; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      conv_cnt_r   <= {CW{1'b0}};
      div_cnt_r    <= {DW{1'b0}};
      bit_cnt_r    <= 4'd0;
      sclk_r       <= 1'b0;
      cs_n_r       <= 1'b0;
      cfg_sh_r     <= 6'd0;
      shift_r      <= 12'd0;
      meas_value_r <= 12'd0;
      meas_valid_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      acc_r        <= 14'd0;
      idx_r        <= 2'd0;
      gap_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      conv_cnt_r   <= conv_cnt_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      sclk_r       <= sclk_nxt_s;
      cs_n_r       <= cs_n_nxt_s;
      cfg_sh_r     <= cfg_sh_nxt_s;
      shift_r      <= shift_nxt_s;
      meas_value_r <= meas_value_nxt_s;
      meas_valid_r <= meas_valid_nxt_s;
      busy_r       <= busy_nxt_s;
`ifdef ADC_OVERSAMPLE_EN
      acc_r        <= acc_nxt_s;
      idx_r        <= idx_nxt_s;
      gap_r        <= gap_nxt_s;
`endif
    end
  end

  assign bus.ADC_SCLK   = sclk_r;
  assign bus.ADC_CS_N   = cs_n_r;
  assign bus.ADC_DIN    = cfg_sh_r[5];
  assign bus.meas_value = meas_value_r;
  assign bus.meas_valid = meas_valid_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: LTC2308 behavioural model plus directed/random conversions.
// Define ADC_OVERSAMPLE_EN for both DUT and bench to exercise the 4x averaging build.
module tb_adc_spi_sampler;
  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 80;
`ifdef ADC_OVERSAMPLE_EN
  localparam int NCONV   = 4;
  localparam int EXP_LAT = 4 * (CONV_CYCLES + 24 * CLK_DIV + 1) + 3 * 2 + 1;
`else
  localparam int NCONV   = 1;
  localparam int EXP_LAT = CONV_CYCLES + 2 * CLK_DIV * 12 + 2;
`endif
  localparam logic [11:0] DIN_EXP = 12'b100010_000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  adc_spi_sampler_if bus();

  adc_spi_sampler #(
    .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .CHANNEL(0), .UNIPOLAR(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // ADC model and pin monitor, evaluated on the falling clk edge.
  logic [11:0] code_q[$];
  logic [11:0] cur_code = 12'h000;
  int          bit_idx = 0;
  logic        cs_prev = 1'b0;
  logic        sclk_prev = 1'b0;
  int          cs_high_cnt = 0;
  int          rise_cnt = 0;
  logic [63:0] din_hist = 64'd0;

  always @(negedge clk) begin
    if (cs_prev && !bus.ADC_CS_N) begin
      if (code_q.size() > 0) cur_code = code_q.pop_front();
      else cur_code = 12'h000;
      bit_idx = 11;
      bus.ADC_DOUT = cur_code[11];
    end else if (sclk_prev && !bus.ADC_SCLK && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      bus.ADC_DOUT = cur_code[bit_idx];
    end
    if (!sclk_prev && bus.ADC_SCLK) begin
      rise_cnt = rise_cnt + 1;
      din_hist = {din_hist[62:0], bus.ADC_DIN};
    end
    if (bus.ADC_CS_N) cs_high_cnt = cs_high_cnt + 1;
    cs_prev   = bus.ADC_CS_N;
    sclk_prev = bus.ADC_SCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result: the code itself, or the truncated mean of four codes.
  function automatic logic [11:0] ref_result(input logic [11:0] a, b, c, d);
    int s;
`ifdef ADC_OVERSAMPLE_EN
    s = (int'(a) + int'(b) + int'(c) + int'(d)) / 4;
`else
    s = int'(a);
`endif
    return 12'(s);
  endfunction

  task automatic check_idle_outputs(input string name);
    check({name, "_sclk"},  {31'd0, bus.ADC_SCLK}, 32'd0);
    check({name, "_cs_n"},  {31'd0, bus.ADC_CS_N}, 32'd0);
    check({name, "_din"},   {31'd0, bus.ADC_DIN},  32'd0);
    check({name, "_value"}, {20'd0, bus.meas_value}, 32'd0);
    check({name, "_valid"}, {31'd0, bus.meas_valid}, 32'd0);
    check({name, "_busy"},  {31'd0, bus.busy},     32'd0);
  endtask

  // One accepted tick at k=0, optional extra ticks at cycles e1..e3, full result checks.
  task automatic run_conv(input string name, input logic [11:0] a, b, c, d,
                          input int e1, input int e2, input int e3);
    logic [11:0] codes [4];
    logic [11:0] exp_v;
    logic [11:0] val;
    logic        busy_ok;
    int          lat, nval, c0, r0, budget;
    codes = '{a, b, c, d};
    exp_v = ref_result(a, b, c, d);
    for (int i = 0; i < NCONV; i++) code_q.push_back(codes[i]);
    budget = EXP_LAT + 20;
    lat = -1; val = 12'h000; nval = 0; busy_ok = 1'b1;
    @(negedge clk); #1;
    c0 = cs_high_cnt; r0 = rise_cnt;
    bus.sample_tick = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk); #1;
      bus.sample_tick = (k == e1) || (k == e2) || (k == e3);
      if (bus.meas_valid) begin
        nval++;
        if (lat < 0) begin lat = k; val = bus.meas_value; end
      end else if (lat < 0 && !bus.busy) begin
        busy_ok = 1'b0;
      end
    end
    bus.sample_tick = 1'b0;
    check({name, "_latency"},   lat, EXP_LAT);
    check({name, "_value"},     {20'd0, val}, {20'd0, exp_v});
    check({name, "_valid_cnt"}, nval, 1);
    check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_busy_end"},  {31'd0, bus.busy}, 32'd0);
    check({name, "_value_hold"}, {20'd0, bus.meas_value}, {20'd0, exp_v});
    check({name, "_cs_high"},   cs_high_cnt - c0, NCONV * CONV_CYCLES);
    check({name, "_sclk_rises"}, rise_cnt - r0, NCONV * 12);
    check({name, "_din_bits"},  {20'd0, din_hist[11:0]}, {20'd0, DIN_EXP});
  endtask

  initial begin
    int found, nval, c0;
    bus.sample_tick = 1'b0;
    rst = 1'b1;
    // Reset held for several cycles while ticks are requested.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      bus.sample_tick = 1'b1;
    end
    @(negedge clk); #1;
    bus.sample_tick = 1'b0;
    check_idle_outputs("reset");
    check("reset_no_convst", cs_high_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    run_conv("a5c", 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C, -1, -1, -1);
    run_conv("zero", 12'h000, 12'h000, 12'h000, 12'h000, -1, -1, -1);
    run_conv("full", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      run_conv("random", 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), -1, -1, -1);
    end
    run_conv("busy_ticks", 12'h3C7, 12'h3C7, 12'h3C7, 12'h3C7, 5, EXP_LAT - 1, EXP_LAT);

    // Reset after the fifth SCLK rise of a transfer.
    code_q.push_back(12'($urandom_range(0, 4095)));
    @(negedge clk); #1;
    c0 = rise_cnt;
    bus.sample_tick = 1'b1;
    @(negedge clk); #1;
    bus.sample_tick = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (rise_cnt - c0 >= 5) begin found = 1; break; end
      @(negedge clk); #1;
    end
    check("midxfer_reached_rise5", found, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check_idle_outputs("midxfer_reset");
    rst = 1'b0;
    code_q.delete();
    nval = 0;
    c0 = cs_high_cnt;
    for (int k = 0; k < EXP_LAT + 20; k++) begin
      @(negedge clk); #1;
      if (bus.meas_valid) nval++;
    end
    check("midxfer_no_valid", nval, 0);
    check("midxfer_no_restart", cs_high_cnt - c0, 0);
    run_conv("post_reset", 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
             12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), -1, -1, -1);

`ifdef ADC_OVERSAMPLE_EN
    run_conv("os_100_103", 12'd100, 12'd101, 12'd102, 12'd103, -1, -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
